// File: rtl/mask_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mask_pkg : shared types/constants for the 2-share masking stage          |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
package mask_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAND = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
  localparam int MAX_W = 16;

  typedef struct packed {
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
  } share_t;

  // Right-shifting Galois step; feedback taps applied when the LSB falls out.
  function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] s);
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : {LFSR_W{1'b0}});
  endfunction

endpackage
`default_nettype wire

// File: rtl/mask_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mask_lfsr : 32-bit Galois LFSR randomness source, advances on step       |
// | Rev 1.0   : initial release                                              |
// +--------------------------------------------------------------------------+
module mask_lfsr
  import mask_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 32'hACE1_2461
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else if (step) begin
      r_state <= lfsrNext(r_state);
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/mask_share_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mask_share_gen : splits plaintext x,y into Boolean share pairs using     |
// |                  fresh randomness. Optional MASK_LFSR_EN selects an      |
// |                  internal LFSR instead of the rand_* handshake.          |
// | Rev 1.0        : initial release                                         |
// +--------------------------------------------------------------------------+
module mask_share_gen
  import mask_pkg::*;
#(
  parameter int          WIDTH     = 1,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2461
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x_i,
  input  logic [WIDTH-1:0]   y_i,
  input  logic               rand_valid,
  output logic               rand_ready,
  input  logic [2*WIDTH-1:0] rand_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Ax_o,
  output logic [WIDTH-1:0]   Bx_o,
  output logic [WIDTH-1:0]   Ay_o,
  output logic [WIDTH-1:0]   By_o,
  output logic [15:0]        draws_o
);

  localparam logic [15:0] c_drawsMax = 16'hFFFF;

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_xHold;
  logic [WIDTH-1:0]   r_yHold;
  logic [WIDTH-1:0]   r_ax;
  logic [WIDTH-1:0]   r_bx;
  logic [WIDTH-1:0]   r_ay;
  logic [WIDTH-1:0]   r_by;
  logic [15:0]        r_draws;
  logic [WIDTH-1:0]   w_rx;
  logic [WIDTH-1:0]   w_ry;
  logic               w_inFire;
  logic               w_randFire;
  logic               w_outFire;

`ifdef MASK_LFSR_EN
  logic [LFSR_W-1:0]  w_lfsrState;
  logic               w_unused;

  mask_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (w_randFire),
    .state (w_lfsrState)
  );

  // Internal source is always ready, so RAND is a single cycle.
  assign w_randFire = (r_state == RAND);
  assign rand_ready = 1'b0;
  assign w_rx       = w_lfsrState[WIDTH-1:0];
  assign w_ry       = w_lfsrState[2*WIDTH-1:WIDTH];
  assign w_unused   = ^{rand_i, rand_valid, w_lfsrState};
`else
  assign w_randFire = (r_state == RAND) && rand_valid;
  assign rand_ready = (r_state == RAND);
  assign w_rx       = rand_i[WIDTH-1:0];
  assign w_ry       = rand_i[2*WIDTH-1:WIDTH];
`endif

  // Handshake outputs are pure state decodes, never fed through from inputs.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == OUT);
  assign w_inFire  = in_ready && in_valid;
  assign w_outFire = out_valid && out_ready;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_inFire)   w_nextState = RAND;
      RAND:    if (w_randFire) w_nextState = OUT;
      OUT:     if (w_outFire)  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Plaintext lives only between accept and the draw that masks it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xHold <= '0;
      r_yHold <= '0;
    end else if (w_inFire) begin
      r_xHold <= x_i;
      r_yHold <= y_i;
    end else if (w_randFire) begin
      r_xHold <= '0;
      r_yHold <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ax <= '0;
      r_bx <= '0;
      r_ay <= '0;
      r_by <= '0;
    end else if (w_randFire) begin
      r_ax <= r_xHold ^ w_rx;
      r_bx <= w_rx;
      r_ay <= r_yHold ^ w_ry;
      r_by <= w_ry;
    end else if (w_outFire) begin
      r_ax <= '0;
      r_bx <= '0;
      r_ay <= '0;
      r_by <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_draws <= '0;
    end else if (w_randFire && (r_draws != c_drawsMax)) begin
      r_draws <= r_draws + 16'd1;
    end
  end

  assign Ax_o    = r_ax;
  assign Bx_o    = r_bx;
  assign Ay_o    = r_ay;
  assign By_o    = r_by;
  assign draws_o = r_draws;

endmodule
`default_nettype wire

// File: tb/tb_mask_share_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mask_share_gen : vector table + randomized model check of the stage   |
// | Rev 1.0           : initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mask_share_gen;

  localparam int W = 4;
  localparam logic [31:0] c_seed = 32'hACE1_2461;
  localparam logic [31:0] c_taps = 32'h8020_0003;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   x_i = '0;
  logic [W-1:0]   y_i = '0;
  logic           rand_valid = 1'b0;
  logic           rand_ready;
  logic [2*W-1:0] rand_i = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   Ax_o, Bx_o, Ay_o, By_o;
  logic [15:0]    draws_o;

  int checks = 0;
  int failures = 0;
  logic [15:0] expDraws = 16'd0;

  always #5 clk = ~clk;

  mask_share_gen #(.WIDTH(W), .LFSR_SEED(c_seed)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .x_i(x_i), .y_i(y_i),
    .rand_valid(rand_valid), .rand_ready(rand_ready), .rand_i(rand_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .Ax_o(Ax_o), .Bx_o(Bx_o), .Ay_o(Ay_o), .By_o(By_o), .draws_o(draws_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chkSharesZero(input string tag);
    chk({tag, "_shares0"}, {16'd0, Ax_o, Bx_o, Ay_o, By_o}, 32'd0);
  endtask

  task automatic bumpDraws();
    if (expDraws != 16'hFFFF) expDraws = expDraws + 16'd1;
  endtask

`ifndef MASK_LFSR_EN
  typedef struct {
    logic [W-1:0]   x, y;
    logic [2*W-1:0] r;
    logic [W-1:0]   ax, bx, ay, by;
    int             waitR, stall;
  } vec_t;

  vec_t vecs[5];

  task automatic acceptPair(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; x_i = x; y_i = y;
    @(negedge clk);
    in_valid = 1'b0; x_i = W'($urandom); y_i = W'($urandom);
    chk("rand_ready_rand", {31'd0, rand_ready}, 32'd1);
    chk("in_ready_rand", {31'd0, in_ready}, 32'd0);
    chk("out_valid_rand", {31'd0, out_valid}, 32'd0);
    chkSharesZero("rand");
  endtask

  task automatic supplyRand(input logic [2*W-1:0] r, input int waitR);
    for (int k = 0; k < waitR; k++) begin
      rand_valid = 1'b0; rand_i = 8'($urandom);
      @(negedge clk);
      chk("rand_wait_ready", {31'd0, rand_ready}, 32'd1);
      chk("rand_wait_outv", {31'd0, out_valid}, 32'd0);
      chkSharesZero("rand_wait");
    end
    rand_valid = 1'b1; rand_i = r;
    @(negedge clk);
    rand_valid = 1'b0; rand_i = 8'($urandom);
    bumpDraws();
  endtask

  task automatic checkOut(input logic [W-1:0] ax, bx, ay, by, input int stall);
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("out_in_ready", {31'd0, in_ready}, 32'd0);
    chk("out_rand_ready", {31'd0, rand_ready}, 32'd0);
    chk("shares", {16'd0, Ax_o, Bx_o, Ay_o, By_o}, {16'd0, ax, bx, ay, by});
    chk("draws", {16'd0, draws_o}, {16'd0, expDraws});
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_shares", {16'd0, Ax_o, Bx_o, Ay_o, By_o}, {16'd0, ax, bx, ay, by});
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
    chkSharesZero("drain");
  endtask

  task automatic runPair(input logic [W-1:0] x, y, input logic [2*W-1:0] r,
                         input int waitR, input int stall);
    acceptPair(x, y);
    supplyRand(r, waitR);
    checkOut(x ^ r[W-1:0], r[W-1:0], y ^ r[2*W-1:W], r[2*W-1:W], stall);
  endtask
`else
  logic [31:0] modelLfsr = c_seed;

  task automatic lfsrPair(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    chk("l_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; x_i = x; y_i = y;
    @(negedge clk);
    in_valid = 1'b0;
    chk("l_rand_state", {29'd0, in_ready, rand_ready, out_valid}, 32'd0);
    chkSharesZero("l_rand");
    @(negedge clk);
    bumpDraws();
    chk("l_out_valid", {31'd0, out_valid}, 32'd1);
    chk("l_recomb", {24'd0, Ax_o ^ Bx_o, Ay_o ^ By_o}, {24'd0, x, y});
    chk("l_rand_used", {24'd0, By_o, Bx_o}, {24'd0, modelLfsr[2*W-1:0]});
    chk("l_draws", {16'd0, draws_o}, {16'd0, expDraws});
    modelLfsr = (modelLfsr >> 1) ^ (modelLfsr[0] ? c_taps : 32'd0);
  endtask
`endif

  initial begin
    #12;
    chk("reset_ctrl", {29'd0, in_ready, rand_ready, out_valid}, 32'b100);
    chkSharesZero("reset");
    chk("reset_draws", {16'd0, draws_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef MASK_LFSR_EN
    vecs[0] = '{x:4'hA, y:4'h3, r:8'h5C, ax:4'h6, bx:4'hC, ay:4'h6, by:4'h5, waitR:0, stall:0};
    vecs[1] = '{x:4'h0, y:4'h0, r:8'h00, ax:4'h0, bx:4'h0, ay:4'h0, by:4'h0, waitR:5, stall:0};
    vecs[2] = '{x:4'hF, y:4'hF, r:8'hFF, ax:4'h0, bx:4'hF, ay:4'h0, by:4'hF, waitR:0, stall:4};
    vecs[3] = '{x:4'h1, y:4'h8, r:8'h37, ax:4'h6, bx:4'h7, ay:4'hB, by:4'h3, waitR:1, stall:1};
    vecs[4] = '{x:4'h5, y:4'hC, r:8'hA0, ax:4'h5, bx:4'h0, ay:4'h6, by:4'hA, waitR:2, stall:2};
    for (int i = 0; i < 5; i++) begin
      acceptPair(vecs[i].x, vecs[i].y);
      supplyRand(vecs[i].r, vecs[i].waitR);
      checkOut(vecs[i].ax, vecs[i].bx, vecs[i].ay, vecs[i].by, vecs[i].stall);
    end

    for (int i = 0; i < 30; i++) begin
      runPair(W'($urandom), W'($urandom), 8'($urandom),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    // Reset while a pair sits in OUT: everything clears asynchronously.
    acceptPair(4'h9, 4'h6);
    supplyRand(8'h3E, 0);
    chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    expDraws = 16'd0;
    chk("async_rst_ctrl", {29'd0, in_ready, rand_ready, out_valid}, 32'b100);
    chkSharesZero("async_rst");
    chk("async_rst_draws", {16'd0, draws_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_no_out", {31'd0, out_valid}, 32'd0);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    end

    // Counter saturation near the top of range.
    force dut.r_draws = 16'hFFFE;
    @(negedge clk);
    release dut.r_draws;
    expDraws = 16'hFFFE;
    runPair(4'h2, 4'h4, 8'h11, 0, 0);
    runPair(4'h7, 4'hD, 8'hC3, 0, 0);
    chk("draws_saturated", {16'd0, draws_o}, 32'h0000_FFFF);
`else
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      lfsrPair(W'($urandom), W'($urandom));
    end
    force dut.r_draws = 16'hFFFE;
    @(negedge clk);
    release dut.r_draws;
    expDraws = 16'hFFFE;
    lfsrPair(4'h2, 4'h4);
    lfsrPair(4'h7, 4'hD);
    chk("draws_saturated", {16'd0, draws_o}, 32'h0000_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
